// File: rtl/bus_scenario_sequencer.sv
// Scenario-driven stimulus sequencer: runs BURST_LEN lockstep write / read-compare /
// write-verify transactions on the selected ADS bus masters and reports the outcome.
module bus_scenario_sequencer #(
    parameter int NUM_M       = 3,
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 8,
    parameter int BURST_LEN   = 4,
    parameter int BASE_ADDR   = 1000,
    parameter int ADDR_STRIDE = 4096,
    parameter int SEED        = 100,
    parameter int EN_PULSE    = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_M+1:0]         state_in,
    output logic [NUM_M-1:0]         m_enable,
    output logic [NUM_M-1:0]         m_read_en,
    output logic [NUM_M*ADDR_W-1:0]  m_addr,
    output logic [NUM_M*DATA_W-1:0]  m_wdata,
    input  logic [NUM_M-1:0]         m_done,
    input  logic [NUM_M*DATA_W-1:0]  m_rdata,
    output logic                     busy,
    output logic                     seq_done,
    output logic                     seq_pass,
    output logic [7:0]               err_cnt,
    output logic                     timeout_flag
);
    localparam int K_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int EN_W = $clog2(EN_PULSE + 1);
    localparam int T_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FINISH} state_t;

    state_t             state;
    logic               start_q, start_edge;
    logic [1:0]         op_r;
    logic [NUM_M-1:0]   mask_r, done_seen, done_new, go_mask;
    logic [K_W-1:0]     k, go_k;
    logic               phase, forced, go, go_rd, all_done;
    logic [EN_W-1:0]    en_cnt;
    logic [T_W-1:0]     tmo_cnt;
    logic [7:0]         mis, err_next;
    logic [8:0]         err_sum;

    wire [1:0]       op_in   = state_in[1:0];
    wire [NUM_M-1:0] mask_in = state_in[NUM_M+1:2];

    function automatic logic [NUM_M*ADDR_W-1:0] bus_addr(input logic [K_W-1:0] kk);
        logic [NUM_M*ADDR_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_M; i++)
            v[i*ADDR_W +: ADDR_W] = ADDR_W'(BASE_ADDR + i*ADDR_STRIDE + int'(kk));
        return v;
    endfunction

    function automatic logic [NUM_M*DATA_W-1:0] bus_data(input logic [K_W-1:0] kk);
        logic [NUM_M*DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_M; i++)
            v[i*DATA_W +: DATA_W] = DATA_W'(SEED + 16*i + int'(kk));
        return v;
    endfunction

    // Read data is checked against m_wdata, which holds the pattern for the current k.
    always_comb begin
        done_new = m_done & mask_r & ~done_seen;
        all_done = ((done_seen | done_new) == mask_r);
        mis = '0;
        for (int i = 0; i < NUM_M; i++)
            if (done_new[i] && phase && m_rdata[i*DATA_W +: DATA_W] != m_wdata[i*DATA_W +: DATA_W])
                mis = mis + 8'd1;
        err_sum  = {1'b0, err_cnt} + {1'b0, mis};
        err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // go marks the cycle in which the next transaction's outputs are loaded.
    always_comb begin
        go      = 1'b0;
        go_k    = k;
        go_rd   = 1'b0;
        go_mask = mask_r;
        case (state)
            IDLE: if (start_edge && op_in != 2'd0 && mask_in != '0) begin
                go      = 1'b1;
                go_k    = '0;
                go_rd   = (op_in == 2'd2);
                go_mask = mask_in;
            end
            NEXT: if (op_r == 2'd3 && !phase) begin
                go    = 1'b1;
                go_rd = 1'b1;
            end else if (k != K_W'(BURST_LEN - 1)) begin
                go    = 1'b1;
                go_k  = k + K_W'(1);
                go_rd = (op_r == 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            start_edge   <= 1'b0;
            op_r         <= '0;
            mask_r       <= '0;
            k            <= '0;
            phase        <= 1'b0;
            forced       <= 1'b0;
            en_cnt       <= '0;
            tmo_cnt      <= '0;
            done_seen    <= '0;
            m_enable     <= '0;
            m_read_en    <= '0;
            m_addr       <= '0;
            m_wdata      <= '0;
            busy         <= 1'b0;
            seq_done     <= 1'b0;
            seq_pass     <= 1'b0;
            err_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            start_q    <= start;
            start_edge <= start && !start_q && (state == IDLE);
            seq_done   <= 1'b0;
            case (state)
                IDLE: if (start_edge) begin
                    op_r         <= op_in;
                    mask_r       <= mask_in;
                    err_cnt      <= '0;
                    timeout_flag <= 1'b0;
                    seq_pass     <= (op_in == 2'd0);
                    k            <= '0;
                    phase        <= 1'b0;
                    busy         <= 1'b1;
                    forced       <= (op_in == 2'd0) || (mask_in == '0);
                    if (op_in == 2'd0 || mask_in == '0)
                        state <= FINISH;
                end
                ISSUE: begin
                    done_seen <= done_seen | done_new;
                    err_cnt   <= err_next;
                    tmo_cnt   <= tmo_cnt + T_W'(1);
                    if (en_cnt == EN_W'(EN_PULSE)) begin
                        m_enable <= '0;
                        state    <= WAIT;
                    end else begin
                        en_cnt <= en_cnt + EN_W'(1);
                    end
                end
                WAIT: begin
                    done_seen <= done_seen | done_new;
                    err_cnt   <= err_next;
                    tmo_cnt   <= tmo_cnt + T_W'(1);
                    // A done arriving on the expiry edge still wins over the timeout.
                    if (all_done) begin
                        state <= NEXT;
                    end else if (tmo_cnt >= T_W'(TIMEOUT - 1)) begin
                        timeout_flag <= 1'b1;
                        state        <= FINISH;
                    end
                end
                NEXT: if (!go) state <= FINISH;
                FINISH: begin
                    seq_done <= 1'b1;
                    busy     <= 1'b0;
                    if (!forced)
                        seq_pass <= (err_cnt == 8'd0) && !timeout_flag;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (go) begin
                state     <= ISSUE;
                k         <= go_k;
                phase     <= go_rd;
                m_enable  <= go_mask;
                m_read_en <= {NUM_M{go_rd}};
                m_addr    <= bus_addr(go_k);
                m_wdata   <= bus_data(go_k);
                en_cnt    <= EN_W'(1);
                tmo_cnt   <= '0;
                done_seen <= '0;
            end
        end
    end
endmodule

// File: tb/tb_bus_scenario_sequencer.sv
// Randomized bench for bus_scenario_sequencer: a slave/memory model acks the masters and a
// transaction-level reference model predicts traffic, error count and pass/timeout results.
module tb_bus_scenario_sequencer;
    localparam int NM = 3, AW = 14, DW = 8, BL = 4;

    logic              clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [NM+1:0]     state_in = '0;
    logic [NM-1:0]     m_enable, m_read_en, m_done;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_wdata, m_rdata;
    logic              busy, seq_done, seq_pass, timeout_flag;
    logic [7:0]        err_cnt;

    bus_scenario_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .state_in(state_in),
        .m_enable(m_enable), .m_read_en(m_read_en), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_done(m_done), .m_rdata(m_rdata), .busy(busy), .seq_done(seq_done),
        .seq_pass(seq_pass), .err_cnt(err_cnt), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct {int m; int k; bit rd; int addr; int data; int rdata; int cyc;} txn_t;

    int        n_cmp = 0, n_bad = 0;
    int        cyc = 0, done_pulses = 0;
    txn_t      obs[$];
    logic [7:0] mem [int];
    bit        noack = 0, spurious = 0;
    int        fixed_delay = 0, corrupt_pct = 0, force_addr = -1;
    logic [NM-1:0] cur_mask = '0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (seq_done) done_pulses <= done_pulses + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int p_addr(int i, int k); return (1000 + i*4096 + k) % 16384; endfunction
    function automatic int p_data(int i, int k); return (100 + 16*i + k) % 256; endfunction

    // Slave + memory: acks each enable rising edge after a delay, serves reads from mem.
    initial begin : slave
        int cd[NM];
        logic [DW-1:0] resp[NM];
        logic [NM-1:0] en_prev;
        txn_t t;
        m_done = '0; m_rdata = '0; en_prev = '0;
        for (int i = 0; i < NM; i++) begin cd[i] = 0; resp[i] = '0; end
        forever begin
            @(negedge clk);
            m_done = '0;
            for (int i = 0; i < NM; i++) m_rdata[i*DW +: DW] = DW'($urandom);
            if (!reset) begin
                for (int i = 0; i < NM; i++) cd[i] = 0;
                en_prev = '0;
            end else begin
                for (int i = 0; i < NM; i++) begin
                    if (cd[i] > 0) begin
                        cd[i]--;
                        if (cd[i] == 0) begin
                            m_done[i] = 1'b1;
                            m_rdata[i*DW +: DW] = resp[i];
                        end
                    end else if (spurious && !cur_mask[i] && $urandom_range(0, 7) == 0) begin
                        m_done[i] = 1'b1;
                    end
                    if (m_enable[i] && !en_prev[i]) begin
                        t.m = i; t.k = -1; t.rd = m_read_en[i]; t.cyc = cyc;
                        t.addr = int'(m_addr[i*AW +: AW]);
                        t.data = int'(m_wdata[i*DW +: DW]);
                        if (t.rd) begin
                            resp[i] = mem.exists(t.addr) ? mem[t.addr] : 8'h00;
                            if ($urandom_range(0, 99) < corrupt_pct) resp[i] = resp[i] ^ 8'h5A;
                            if (t.addr == force_addr) resp[i] = 8'h00;
                        end else begin
                            mem[t.addr] = m_wdata[i*DW +: DW];
                        end
                        t.rdata = int'(resp[i]);
                        obs.push_back(t);
                        if (!noack) cd[i] = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, 6);
                    end
                end
                en_prev = m_enable;
            end
        end
    end

    task automatic run_seq(input logic [1:0] op, input logic [NM-1:0] mask, input bit hold2,
                           input bit exp_tmo, input bit chk_lat);
        txn_t exp_q[$];
        txn_t e;
        int c0, t, err, base_pulses, n;
        bit exp_pass;
        obs.delete();
        cur_mask = mask;
        // Reference: every (k, phase) step issues once on each selected master, in index order.
        if (op != 2'd0 && mask != '0)
            for (int k = 0; k < BL; k++)
                for (int ph = 0; ph < ((op == 2'd3) ? 2 : 1); ph++)
                    for (int i = 0; i < NM; i++)
                        if (mask[i]) begin
                            e.m = i; e.k = k; e.rd = (op == 2'd2) || (ph == 1);
                            e.addr = p_addr(i, k); e.data = p_data(i, k); e.rdata = 0; e.cyc = 0;
                            exp_q.push_back(e);
                        end
        if (exp_tmo) while (exp_q.size() > $countones(mask)) void'(exp_q.pop_back());

        base_pulses = done_pulses;
        @(negedge clk);
        c0 = cyc;
        state_in = {mask, op};
        start = 1'b1;
        @(negedge clk);
        if (hold2) @(negedge clk);
        start = 1'b0;
        if (hold2) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (!seq_done && t < 3000) begin @(negedge clk); t++; end
        chk("seq_done_seen", seq_done, 1'b1);

        err = 0;
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int j = 0; j < n; j++)
            if (exp_q[j].rd && obs[j].rdata != p_data(exp_q[j].m, exp_q[j].k)) err++;
        if (err > 255) err = 255;
        exp_pass = (op == 2'd0) ? 1'b1 : (mask == '0) ? 1'b0 : (err == 0 && !exp_tmo);

        chk("seq_pass", seq_pass, exp_pass);
        chk("err_cnt", err_cnt, err);
        chk("timeout_flag", timeout_flag, exp_tmo);
        chk("busy_at_done", busy, 1'b0);
        if (exp_tmo && obs.size() > 0)
            chk("tmo_latency_in_range", (cyc - obs[0].cyc >= 64) && (cyc - obs[0].cyc <= 67), 1'b1);
        if (chk_lat && obs.size() > 0) chk("start_to_enable", obs[0].cyc - c0, 2);

        repeat (8) @(negedge clk);
        chk("seq_done_count", done_pulses - base_pulses, 1);
        chk("txn_count", obs.size(), exp_q.size());
        for (int j = 0; j < n; j++) begin
            chk("txn_master", obs[j].m, exp_q[j].m);
            chk("txn_read_en", obs[j].rd, exp_q[j].rd);
            chk("txn_addr", obs[j].addr, exp_q[j].addr);
            if (!exp_q[j].rd) chk("txn_wdata", obs[j].data, exp_q[j].data);
        end
    endtask

    initial begin : main
        logic [NM-1:0] en_acc;
        int t;
        for (int i = 0; i < NM; i++)
            for (int k = 0; k < BL; k++) mem[p_addr(i, k)] = 8'(p_data(i, k));

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, seq_done, seq_pass, timeout_flag, err_cnt, m_enable, m_read_en}, 0);
        chk("reset_addr", m_addr, 0);
        chk("reset_wdata", m_wdata, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        fixed_delay = 5;
        run_seq(2'd1, 3'b001, 0, 0, 1);
        fixed_delay = 0;
        run_seq(2'd3, 3'b111, 0, 0, 0);
        force_addr = p_addr(1, 2);
        run_seq(2'd2, 3'b010, 0, 0, 0);
        force_addr = -1;

        noack = 1;
        run_seq(2'd1, 3'b100, 0, 1, 0);
        noack = 0;
        en_acc = '0;
        repeat (10) begin @(negedge clk); en_acc |= m_enable; end
        chk("enable_quiet_after_tmo", en_acc, 0);

        run_seq(2'd1, 3'b011, 1, 0, 0);
        run_seq(2'd0, 3'b101, 0, 0, 0);
        run_seq(2'd1, 3'b000, 0, 0, 0);

        // Asynchronous reset while a write-verify burst is in flight.
        noack = 1;
        @(negedge clk);
        state_in = {3'b111, 2'd3};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (m_enable == '0 && t < 20) begin @(negedge clk); t++; end
        chk("pre_reset_enable", m_enable, 3'b111);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_ctrl", {busy, seq_done, seq_pass, timeout_flag, err_cnt, m_enable, m_read_en}, 0);
        chk("async_rst_addr", m_addr, 0);
        chk("async_rst_wdata", m_wdata, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        noack = 0;
        repeat (2) @(negedge clk);
        run_seq(2'd1, 3'b001, 0, 0, 0);

        for (int r = 0; r < 12; r++) begin
            corrupt_pct = $urandom_range(0, 1) * 30;
            spurious    = bit'($urandom_range(0, 1));
            run_seq(2'($urandom_range(1, 3)), 3'($urandom_range(1, 7)), 0, 0, 0);
        end
        spurious = 0;
        corrupt_pct = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_scenario_sequencer.md
Name: bus_scenario_sequencer

Overview:
Parametrised stimulus sequencer for the ADS bus. It drives the request ports of NUM_M bus masters from a scenario code plus a start strobe, replacing hand-sequenced enable/read_en/addr/data stimulus. Each start runs BURST_LEN lockstep transactions on the selected masters (write, read-and-compare, or write-then-verify). It reports busy, completion, pass/fail, an error count and timeouts, and sits between the top-level control inputs and the master blocks.

Parameters:
NUM_M, 3, number of master channels driven.
ADDR_W, 14, address width per master.
DATA_W, 8, data width per master.
BURST_LEN, 4, transactions per master per start (≥1).
BASE_ADDR, 1000, address of master 0, iteration 0.
ADDR_STRIDE, 4096, address offset between consecutive masters.
SEED, 100, data pattern seed.
EN_PULSE, 2, cycles m_enable is held high per transaction (≥1).
TIMEOUT, 64, max cycles from issue to all selected m_done.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  sequence request; rising edge triggers.
state_in  in  2+NUM_M  [1:0] op (0 nop, 1 write, 2 read, 3 write-verify); [2+i] selects master i.
m_enable  out  NUM_M  per-master transaction enable.
m_read_en  out  NUM_M  per-master read (1) / write (0).
m_addr  out  NUM_M*ADDR_W  per-master address; slice i = [i*ADDR_W +: ADDR_W].
m_wdata  out  NUM_M*DATA_W  per-master write data; slice i = [i*DATA_W +: DATA_W].
m_done  in  NUM_M  per-master one-cycle completion pulse.
m_rdata  in  NUM_M*DATA_W  per-master read data; valid on the m_done cycle.
busy  out  1  sequence in progress.
seq_done  out  1  one-cycle pulse at end of sequence.
seq_pass  out  1  result of last sequence; held until next accepted start.
err_cnt  out  8  read mismatches in the last sequence; saturates at 255.
timeout_flag  out  1  a transaction timed out in the last sequence.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; every output 0; counters, done-mask and start edge register cleared. Mid-sequence reset aborts and drops m_enable the same instant.
- Start is a registered rising edge (start=1, start_q=0) seen in IDLE. Edges while busy are ignored. A start held high across seq_done does not retrigger.
- On an accepted start, latch op and mask, clear err_cnt, timeout_flag and seq_pass, and clear iteration k=0.
- Pattern for master i, iteration k: addr = (BASE_ADDR + i*ADDR_STRIDE + k) mod 2^ADDR_W; data = (SEED + 16*i + k) mod 2^DATA_W.
- FSM states: IDLE -> ISSUE -> WAIT -> (NEXT) -> FINISH -> IDLE.
- IDLE: busy=0.
  - Accepted start with op=0 -> FINISH, seq_pass=1.
  - Accepted start with op≠0 and mask=0 -> FINISH, seq_pass=0.
  - Otherwise -> ISSUE.
- ISSUE: the cycle after start is accepted, busy=1. m_enable[i]=mask[i] for EN_PULSE cycles; addr, data and read_en are stable throughout. read_en=1 for op 2 and for the verify phase of op 3. Timeout counter is cleared on ISSUE entry. -> WAIT after EN_PULSE cycles.
- m_done is accepted in both ISSUE and WAIT and latched into done_seen. m_done on unselected masters is ignored.
- Read compare: on m_done[i] of a read, compare m_rdata slice i with the pattern; on mismatch, err_cnt += 1 (saturating).
- WAIT: exit when done_seen == mask. If the timeout counter reaches TIMEOUT first, set timeout_flag and abandon the rest of the sequence -> FINISH.
- Op 3 sequencing: write phase at k, then a read phase at the same k, then k+1.
- NEXT: if k == BURST_LEN-1 (and the read phase is done for op 3) -> FINISH; otherwise advance and -> ISSUE.
- FINISH: seq_done=1 for one cycle; seq_pass = (err_cnt==0 && !timeout_flag) unless already forced by the IDLE cases; busy=0 from the next cycle -> IDLE.
- m_done arriving at the same edge as the timeout expiry counts as done (done has priority).
- Timing: a start at edge n gives the first m_enable high at edge n+2 (edge register + accept).

Test Plan:
- Op 1, mask 001, slave acks 5 cycles after enable -> m_addr0 = 1000,1001,1002,1003 with wdata 100..103, m_read_en=0; one seq_done; seq_pass=1; err_cnt=0.
- Op 3, mask 111, memory model -> master1 writes 5096/116 then reads it back; master2 uses 9192/132; 8 transactions per master; seq_pass=1.
- Op 2, mask 010, model returns 8'd0 at k=2 -> err_cnt=1, seq_pass=0, sequence completes all 4 reads.
- Op 1, mask 100, m_done never asserted -> timeout_flag=1 at 64 cycles after issue; seq_done pulse; seq_pass=0; m_enable stays 0 afterwards.
- start held 2 cycles, plus a second start pulse while busy -> exactly one sequence. Op 0 -> seq_done without any m_enable, seq_pass=1. Mask 0 with op 1 -> seq_pass=0.
- reset=0 during WAIT of op 3 -> all outputs 0 immediately. After release, a new op 1 start runs from k=0 (addr 1000).
